// File: rtl/mux_rr_arbiter.sv
// Registered N-input channel multiplexer with valid/ready handshakes.
// Channels are chosen by direct select (mode=0) or round-robin arbitration (mode=1).
module mux_rr_arbiter #(
    parameter int WIDTH    = 32,
    parameter int N_INPUTS = 4,
    parameter int SEL_W    = $clog2(N_INPUTS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          select,
    input  logic [N_INPUTS*WIDTH-1:0] in_data,
    input  logic [N_INPUTS-1:0]       in_valid,
    output logic [N_INPUTS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_channel
);

    localparam int unsigned N = N_INPUTS;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_INPUTS - 1);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_channel_q, out_channel_d;
    logic [SEL_W-1:0] last_grant_q, last_grant_d;

    logic             load;
    logic             grant_vld;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] sel_data;
    int unsigned      rr_idx;

    assign load = !out_valid_q || out_ready;

    // Direct select compares against every legal index, so out-of-range selects never match.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        rr_idx    = 0;
        if (!mode) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (select == SEL_W'(i) && in_valid[i]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = 1; k <= N; k++) begin
                rr_idx = (32'(last_grant_q) + k) % N;
                if (!grant_vld && in_valid[rr_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SEL_W'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (grant_idx == SEL_W'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < N; i++) begin
            in_ready[i] = reset_n && load && grant_vld && (grant_idx == SEL_W'(i));
        end
    end

    always_comb begin
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        out_channel_d = out_channel_q;
        last_grant_d  = last_grant_q;
        if (load) begin
            if (grant_vld) begin
                out_data_d    = sel_data;
                out_channel_d = grant_idx;
                out_valid_d   = 1'b1;
                if (mode) begin
                    last_grant_d = grant_idx;
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            out_channel_q <= '0;
            last_grant_q  <= LAST_IDX;
        end else begin
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            out_channel_q <= out_channel_d;
            last_grant_q  <= last_grant_d;
        end
    end

    assign out_data    = out_data_q;
    assign out_valid   = out_valid_q;
    assign out_channel = out_channel_q;

endmodule
